// File: rtl/sprite_dispatcher.sv
// Sprite table plus per-frame dispatcher: on each new video frame, walks the table,
// advances animation phase and hands in-bounds sprites to the compositor one at a time.
module sprite_dispatcher #(
    parameter int MAX_SPRITES         = 16,
    parameter int CANVAS_WIDTH        = 360,
    parameter int CANVAS_HEIGHT       = 720,
    parameter int SPRITE_FRAME_WIDTH  = 64,
    parameter int SPRITE_FRAME_HEIGHT = 64,
    parameter int NUM_FRAMES          = 512,
    parameter int ANIM_DIV            = 4,
    parameter int MAX_ANIM            = 8
) (
    input  logic                              clk_pixel,
    input  logic                              sys_rst_n,
    input  logic [5:0]                        frame_count,
    input  logic                              wr_en,
    input  logic [$clog2(MAX_SPRITES)-1:0]    wr_idx,
    input  logic                              wr_active,
    input  logic [$clog2(CANVAS_WIDTH)-1:0]   wr_x,
    input  logic [$clog2(CANVAS_HEIGHT)-1:0]  wr_y,
    input  logic [$clog2(NUM_FRAMES)-1:0]     wr_base_frame,
    input  logic [$clog2(MAX_ANIM+1)-1:0]     wr_anim_len,
    input  logic                              sprite_ready,
    output logic                              sprite_valid,
    output logic [$clog2(CANVAS_WIDTH)-1:0]   sprite_x,
    output logic [$clog2(CANVAS_HEIGHT)-1:0]  sprite_y,
    output logic [$clog2(NUM_FRAMES)-1:0]     sprite_frame_number,
    output logic                              busy,
    output logic                              overrun
);
    localparam int IW = $clog2(MAX_SPRITES);
    localparam int XW = $clog2(CANVAS_WIDTH);
    localparam int YW = $clog2(CANVAS_HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int LW = $clog2(MAX_ANIM + 1);
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [XW-1:0] X_MAX    = XW'(CANVAS_WIDTH - SPRITE_FRAME_WIDTH);
    localparam logic [YW-1:0] Y_MAX    = YW'(CANVAS_HEIGHT - SPRITE_FRAME_HEIGHT);
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_SPRITES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_GUARD      = 3'd3,
        ST_WAIT_READY = 3'd4
    } state_t;

    function automatic logic [LW-1:0] next_phase(input logic [LW-1:0] ph, input logic [LW-1:0] len);
        if (len <= LW'(1)) begin
            return '0;
        end else if (ph + LW'(1) == len) begin
            return '0;
        end else begin
            return ph + LW'(1);
        end
    endfunction

    logic          active_r [MAX_SPRITES];
    logic [XW-1:0] x_r      [MAX_SPRITES];
    logic [YW-1:0] y_r      [MAX_SPRITES];
    logic [FW-1:0] base_r   [MAX_SPRITES];
    logic [LW-1:0] len_r    [MAX_SPRITES];
    logic [LW-1:0] phase_r  [MAX_SPRITES];

    logic [5:0]    prev_frame_r;
    logic          armed_r;
    logic [DW-1:0] div_r;
    logic          new_frame_s;
    logic          wrap_s;
    logic          skip_s;
    logic          latch_s;

    state_t        state_r, state_next;
    logic [IW-1:0] idx_r, idx_next;
    logic          guard_r, guard_next;
    logic          restart_r, restart_next;

    logic          sprite_valid_r;
    logic [XW-1:0] sprite_x_r;
    logic [YW-1:0] sprite_y_r;
    logic [FW-1:0] sprite_frame_r;
    logic          busy_r;
    logic          overrun_r;

    // armed_r keeps the first post-reset clock from seeing a bogus frame change
    assign new_frame_s = armed_r && (frame_count != prev_frame_r);
    assign wrap_s      = new_frame_s && (div_r == DIV_LAST);
    assign skip_s      = !active_r[idx_r] || (x_r[idx_r] > X_MAX) || (y_r[idx_r] > Y_MAX);

    // Frame-change detection and animation divider
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_frame_r <= 6'd0;
            armed_r      <= 1'b0;
            div_r        <= '0;
        end else begin
            prev_frame_r <= frame_count;
            armed_r      <= 1'b1;
            if (new_frame_s) begin
                div_r <= wrap_s ? '0 : div_r + DW'(1);
            end
        end
    end

    // Sprite table; a write overrides a same-cycle animation step on that entry
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                active_r[i] <= 1'b0;
                x_r[i]      <= '0;
                y_r[i]      <= '0;
                base_r[i]   <= '0;
                len_r[i]    <= '0;
                phase_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                if (wr_en && (wr_idx == IW'(i))) begin
                    active_r[i] <= wr_active;
                    x_r[i]      <= wr_x;
                    y_r[i]      <= wr_y;
                    base_r[i]   <= wr_base_frame;
                    len_r[i]    <= wr_anim_len;
                    phase_r[i]  <= '0;
                end else if (wrap_s && active_r[i]) begin
                    phase_r[i] <= next_phase(phase_r[i], len_r[i]);
                end
            end
        end
    end

    // Walk state register
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            guard_r   <= 1'b0;
            restart_r <= 1'b0;
        end else begin
            state_r   <= state_next;
            idx_r     <= idx_next;
            guard_r   <= guard_next;
            restart_r <= restart_next;
        end
    end

    // Walk next-state logic; an abort during ISSUE/GUARD is deferred until the guard ends
    always_comb begin
        state_next   = state_r;
        idx_next     = idx_r;
        guard_next   = guard_r;
        restart_next = restart_r;
        latch_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (new_frame_s) begin
                    idx_next     = '0;
                    restart_next = 1'b0;
                    state_next   = ST_CHECK;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (new_frame_s) begin
                    idx_next   = '0;
                    state_next = ST_CHECK;
                end else if (!skip_s) begin
                    latch_s    = 1'b1;
                    state_next = ST_WAIT_READY;
                end else if (idx_r == LAST_IDX) begin
                    state_next = ST_IDLE;
                end else begin
                    idx_next = idx_r + IW'(1);
                end
            end
            ST_WAIT_READY: begin
                if (new_frame_s) begin
                    idx_next   = '0;
                    state_next = ST_CHECK;
                end else if (sprite_ready) begin
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_WAIT_READY;
                end
            end
            ST_ISSUE: begin
                guard_next   = 1'b0;
                restart_next = restart_r | new_frame_s;
                state_next   = ST_GUARD;
            end
            ST_GUARD: begin
                if (guard_r == 1'b0) begin
                    guard_next   = 1'b1;
                    restart_next = restart_r | new_frame_s;
                end else if (restart_r || new_frame_s) begin
                    idx_next     = '0;
                    restart_next = 1'b0;
                    state_next   = ST_CHECK;
                end else if (idx_r == LAST_IDX) begin
                    state_next = ST_IDLE;
                end else begin
                    idx_next   = idx_r + IW'(1);
                    state_next = ST_CHECK;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered compositor-facing outputs
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sprite_valid_r <= 1'b0;
            sprite_x_r     <= '0;
            sprite_y_r     <= '0;
            sprite_frame_r <= '0;
            busy_r         <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            sprite_valid_r <= (state_next == ST_ISSUE);
            busy_r         <= (state_next != ST_IDLE);
            overrun_r      <= new_frame_s && (state_r != ST_IDLE);
            if (latch_s) begin
                sprite_x_r     <= x_r[idx_r];
                sprite_y_r     <= y_r[idx_r];
                sprite_frame_r <= base_r[idx_r] + FW'(phase_r[idx_r]);
            end
        end
    end

    assign sprite_valid        = sprite_valid_r;
    assign sprite_x            = sprite_x_r;
    assign sprite_y            = sprite_y_r;
    assign sprite_frame_number = sprite_frame_r;
    assign busy                = busy_r;
    assign overrun             = overrun_r;
endmodule

// File: tb/tb_sprite_dispatcher.sv
// Scoreboard bench for sprite_dispatcher: a table-level reference model predicts the
// sprites of each frame walk; a negedge monitor checks every valid pulse against it.
module tb_sprite_dispatcher;
    localparam int NS = 16;
    localparam int XW = 9;
    localparam int YW = 10;
    localparam int FW = 9;
    localparam int LW = 4;
    localparam int IW = 4;
    localparam int ANIM_DIV = 4;
    localparam int X_LIMIT = 360 - 64;
    localparam int Y_LIMIT = 720 - 64;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [FW-1:0] f;
    } spr_t;

    logic          clk_pixel = 1'b0;
    logic          sys_rst_n;
    logic [5:0]    frame_count;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          wr_active;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [FW-1:0] wr_base_frame;
    logic [LW-1:0] wr_anim_len;
    logic          sprite_ready;
    logic          sprite_valid;
    logic [XW-1:0] sprite_x;
    logic [YW-1:0] sprite_y;
    logic [FW-1:0] sprite_frame_number;
    logic          busy;
    logic          overrun;

    sprite_dispatcher dut (
        .clk_pixel(clk_pixel), .sys_rst_n(sys_rst_n), .frame_count(frame_count),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_active(wr_active), .wr_x(wr_x), .wr_y(wr_y),
        .wr_base_frame(wr_base_frame), .wr_anim_len(wr_anim_len),
        .sprite_ready(sprite_ready), .sprite_valid(sprite_valid), .sprite_x(sprite_x),
        .sprite_y(sprite_y), .sprite_frame_number(sprite_frame_number),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vcount = 0;
    int ov_cnt = 0;
    int last_vcyc = -1000;
    int holdoff_cfg = 0;
    bit force_low = 1'b0;
    bit capture_en = 1'b0;
    spr_t sb_q[$];
    int cap_q[$];

    // reference model state
    bit m_active[NS];
    int m_x[NS], m_y[NS], m_base[NS], m_len[NS], m_phase[NS];
    int m_div = 0;

    always @(posedge clk_pixel) cyc++;

    // compositor: drops ready for holdoff_cfg cycles after each accepted sprite
    initial begin
        bit v;
        int hold;
        hold = 0;
        sprite_ready = 1'b1;
        forever begin
            @(negedge clk_pixel);
            v = sprite_valid;
            @(posedge clk_pixel);
            #1;
            if (v) hold = holdoff_cfg;
            else if (hold > 0) hold--;
            sprite_ready = !force_low && (hold == 0);
        end
    end

    // monitor
    always @(negedge clk_pixel) begin
        spr_t e;
        if (sys_rst_n) begin
            if (overrun) ov_cnt++;
            if (sprite_valid) begin
                vcount++;
                total++;
                if (!sprite_ready) begin
                    bad++;
                    $display("FAIL valid_while_not_ready: ready=%0b required 1", sprite_ready);
                end
                total++;
                if (cyc - last_vcyc < 3) begin
                    bad++;
                    $display("FAIL valid_spacing: gap=%0d required >=3", cyc - last_vcyc);
                end
                last_vcyc = cyc;
                if (capture_en) cap_q.push_back(int'(sprite_frame_number));
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: x=%0d y=%0d f=%0d, none expected",
                             sprite_x, sprite_y, sprite_frame_number);
                end else begin
                    e = sb_q.pop_front();
                    if (sprite_x != e.x || sprite_y != e.y || sprite_frame_number != e.f) begin
                        bad++;
                        $display("FAIL sprite: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                                 sprite_x, sprite_y, sprite_frame_number, e.x, e.y, e.f);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_active[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_base[i] = 0; m_len[i] = 0; m_phase[i] = 0;
        end
        m_div = 0;
    endtask

    task automatic model_write(input int i, input bit a, input int x, input int y, input int b, input int l);
        m_active[i] = a; m_x[i] = x; m_y[i] = y; m_base[i] = b; m_len[i] = l; m_phase[i] = 0;
    endtask

    task automatic write_entry(input int i, input bit a, input int x, input int y, input int b, input int l);
        @(negedge clk_pixel);
        wr_en = 1'b1; wr_idx = IW'(i); wr_active = a; wr_x = XW'(x); wr_y = YW'(y);
        wr_base_frame = FW'(b); wr_anim_len = LW'(l);
        model_write(i, a, x, y, b, l);
        @(posedge clk_pixel);
        #1 wr_en = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NS; i++) write_entry(i, 1'b0, 0, 0, 0, 0);
    endtask

    // frame change (optionally with a coincident write); pushes the predicted walk
    task automatic do_frame(input bit flush, input bit wr, input int i, input int x, input int y,
                            input int b, input int l);
        spr_t e;
        @(negedge clk_pixel);
        frame_count = frame_count + 6'd1;
        m_div = (m_div + 1) % ANIM_DIV;
        if (m_div == 0) begin
            for (int k = 0; k < NS; k++)
                if (m_active[k]) m_phase[k] = (m_len[k] <= 1) ? 0 : (m_phase[k] + 1) % m_len[k];
        end
        if (wr) begin
            wr_en = 1'b1; wr_idx = IW'(i); wr_active = 1'b1; wr_x = XW'(x); wr_y = YW'(y);
            wr_base_frame = FW'(b); wr_anim_len = LW'(l);
            model_write(i, 1'b1, x, y, b, l);
        end
        if (flush) sb_q.delete();
        for (int k = 0; k < NS; k++) begin
            if (m_active[k] && m_x[k] <= X_LIMIT && m_y[k] <= Y_LIMIT) begin
                e.x = XW'(m_x[k]);
                e.y = YW'(m_y[k]);
                e.f = FW'((m_base[k] + m_phase[k]) % 512);
                sb_q.push_back(e);
            end
        end
        @(posedge clk_pixel);
        #1 wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 4000) begin
            @(negedge clk_pixel);
            n++;
        end
        check({name, "_walk_done"}, int'(busy), 0);
        repeat (2) @(negedge clk_pixel);
        check({name, "_drain"}, sb_q.size(), 0);
    endtask

    initial begin
        int v0, ov0, n;
        bit quiet;
        int exp_anim[13] = '{8, 8, 8, 8, 9, 9, 9, 9, 10, 10, 10, 10, 8};

        sys_rst_n = 1'b0; frame_count = 6'd7; wr_en = 1'b0; wr_idx = '0; wr_active = 1'b0;
        wr_x = '0; wr_y = '0; wr_base_frame = '0; wr_anim_len = '0;
        model_reset();
        repeat (4) @(negedge clk_pixel);
        check("reset_valid", int'(sprite_valid), 0);
        check("reset_busy", int'(busy), 0);
        sys_rst_n = 1'b1;

        // no frame change -> nothing happens
        quiet = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_pixel);
            if (busy || sprite_valid) quiet = 1'b0;
        end
        check("idle_quiet", int'(quiet), 1);

        // two entries, ready tied high
        write_entry(0, 1'b1, 10, 20, 5, 1);
        write_entry(3, 1'b1, 100, 300, 40, 1);
        v0 = vcount;
        do_frame(1'b0, 1'b0, 0, 0, 0, 0, 0);
        check("two_busy_rise", int'(busy), 1);
        wait_idle("two");
        check("two_count", vcount - v0, 2);

        // canvas boundaries
        clear_table();
        write_entry(0, 1'b1, 297, 10, 1, 1);
        write_entry(1, 1'b1, 10, 657, 2, 1);
        write_entry(2, 1'b1, 296, 656, 100, 1);
        v0 = vcount;
        do_frame(1'b0, 1'b0, 0, 0, 0, 0, 0);
        wait_idle("bound");
        check("bound_count", vcount - v0, 1);

        // animation: write lands on the divider wrap, then 12 more frames
        clear_table();
        while (m_div != ANIM_DIV - 1) begin
            do_frame(1'b0, 1'b0, 0, 0, 0, 0, 0);
            wait_idle("anim_pre");
        end
        cap_q.delete();
        capture_en = 1'b1;
        do_frame(1'b0, 1'b1, 5, 50, 60, 8, 3);
        wait_idle("anim");
        for (int f = 0; f < 12; f++) begin
            do_frame(1'b0, 1'b0, 0, 0, 0, 0, 0);
            wait_idle("anim");
        end
        capture_en = 1'b0;
        check("anim_len", cap_q.size(), 13);
        for (int k = 0; k < 13 && k < cap_q.size(); k++) check("anim_seq", cap_q[k], exp_anim[k]);

        // randomized tables and compositor latency
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NS; i++)
                write_entry(i, $urandom_range(0, 3) != 0, $urandom_range(0, 330), $urandom_range(0, 700),
                            $urandom_range(0, 511), $urandom_range(0, 8));
            holdoff_cfg = $urandom_range(0, 6);
            n = $urandom_range(1, 4);
            for (int f = 0; f < n; f++) begin
                do_frame(1'b0, 1'b0, 0, 0, 0, 0, 0);
                wait_idle("rand");
            end
        end

        // overrun: new frame lands while waiting on a slow compositor
        clear_table();
        write_entry(0, 1'b1, 11, 21, 30, 1);
        write_entry(1, 1'b1, 12, 22, 31, 1);
        write_entry(2, 1'b1, 13, 23, 32, 1);
        holdoff_cfg = 64;
        repeat (70) @(negedge clk_pixel);
        ov0 = ov_cnt;
        v0 = vcount;
        do_frame(1'b0, 1'b0, 0, 0, 0, 0, 0);
        n = 0;
        while (vcount == v0 && n < 2000) begin
            @(negedge clk_pixel);
            n++;
        end
        check("ovr_first_issue", vcount - v0, 1);
        repeat (10) @(negedge clk_pixel);
        do_frame(1'b1, 1'b0, 0, 0, 0, 0, 0);
        wait_idle("ovr");
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_total_issues", vcount - v0, 4);
        holdoff_cfg = 0;

        // async reset while parked in WAIT_READY
        force_low = 1'b1;
        repeat (2) @(negedge clk_pixel);
        do_frame(1'b0, 1'b0, 0, 0, 0, 0, 0);
        repeat (20) @(negedge clk_pixel);
        check("rstw_busy", int'(busy), 1);
        check("rstw_latched_x", int'(sprite_x), 11);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rstw_x", int'(sprite_x), 0);
        check("rstw_y", int'(sprite_y), 0);
        check("rstw_frame", int'(sprite_frame_number), 0);
        check("rstw_busy_low", int'(busy), 0);
        check("rstw_valid", int'(sprite_valid), 0);
        sb_q.delete();
        model_reset();
        force_low = 1'b0;
        last_vcyc = -1000;
        repeat (3) @(negedge clk_pixel);
        #2 sys_rst_n = 1'b1;
        repeat (10) @(negedge clk_pixel);
        check("rstw_no_spurious", int'(busy), 0);
        v0 = vcount;
        do_frame(1'b0, 1'b0, 0, 0, 0, 0, 0);
        wait_idle("rstw");
        check("rstw_table_empty", vcount - v0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
